// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding,
// default word width and an elaboration-time ceil(log2) helper.
package fifo_arb_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Never returns less than 1, so a width derived from it is always legal.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits++;
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: returns the first set request
// found searching upward from start, wrapping past NUM_REQ-1 back to 0.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    // Scan from the farthest offset down so the nearest request is written last.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(start) + off;
            if (idx >= NUM_REQ) idx -= NUM_REQ;
            if (req[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ producers,
// granting bounded bursts and back-pressuring everyone while the FIFO is full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic [clog2(NUM_REQ)-1:0] grant_id,
    output logic                      grant_active
);

    localparam int ID_W   = clog2(NUM_REQ);
    localparam int BEAT_W = clog2(BURST_MAX + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_MAX - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_e        state, state_n;
    logic [ID_W-1:0]   grant_id_n, rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]   next_id, pick_start, pick_id;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_n;
    logic              pick_found, owner_valid, xfer, release_grant;

    assign owner_valid = req_valid[grant_id];
    assign xfer        = (state == GRANT) & owner_valid & ~fifo_full;

    // Full only stalls the burst; release comes from burst end or withdrawal.
    assign release_grant = (state == GRANT) &
                           (~owner_valid | (xfer & (beat_cnt == LAST_BEAT)));

    assign next_id    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    assign pick_start = (state == IDLE) ? rr_ptr : next_id;

    // Starting one past the releasing grantee makes it the lowest priority.
    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_picker (
        .req    (req_valid),
        .start  (pick_start),
        .found  (pick_found),
        .winner (pick_id)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values that were present before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            grant_id <= grant_id_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    // NOTE: each signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        grant_id_n = grant_id;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n    = GRANT;
                    grant_id_n = pick_id;
                    beat_cnt_n = '0;
                end
            end
            GRANT: begin
                if (xfer) beat_cnt_n = beat_cnt + 1'b1;
                if (release_grant) begin
                    rr_ptr_n   = next_id;
                    beat_cnt_n = '0;
                    if (pick_found) grant_id_n = pick_id;
                    else            state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        grant_active = (state == GRANT);
        fifo_wr_en   = xfer;
        req_ready    = '0;
        if ((state == GRANT) && !fifo_full) req_ready[grant_id] = 1'b1;
        fifo_data_in = req_data[int'(grant_id) * DATA_W +: DATA_W];
    end

endmodule
